// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch controller: FSM state, branch-type codes, default widths.
package branch_ctrl_pkg;

    localparam int unsigned PC_W_DEF  = 10;
    localparam int unsigned OFF_W_DEF = 8;
    localparam int unsigned BR_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_BEQ  = 2'b01;
    localparam logic [BR_W-1:0] BR_BLT  = 2'b10;
    localparam logic [BR_W-1:0] BR_JMP  = 2'b11;

endpackage

// File: rtl/branch_ctrl_flag_reg.sv
// Two-bit condition flag register: write-enable gated load, synchronous clear, otherwise hold.
module branch_ctrl_flag_reg (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic we_i,
    input  logic zero_i,
    input  logic lt_i,
    output logic flag_z_o,
    output logic flag_lt_o
);

    logic flag_z_q,  flag_z_d;
    logic flag_lt_q, flag_lt_d;

    always_comb begin
        flag_z_d  = flag_z_q;
        flag_lt_d = flag_lt_q;
        if (clr_i) begin
            flag_z_d  = 1'b0;
            flag_lt_d = 1'b0;
        end else if (we_i) begin
            flag_z_d  = zero_i;
            flag_lt_d = lt_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flag_z_q  <= 1'b0;
            flag_lt_q <= 1'b0;
        end else begin
            flag_z_q  <= flag_z_d;
            flag_lt_q <= flag_lt_d;
        end
    end

    assign flag_z_o  = flag_z_q;
    assign flag_lt_o = flag_lt_q;

endmodule

// File: rtl/branch_ctrl.sv
// Program-counter sequencer: IDLE/RUN/DONE control, PC-relative branches on latched ALU flags.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned OFF_W = OFF_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [PC_W-1:0]  start_addr_i,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             flag_we_i,
    input  logic             zero_i,
    input  logic             lt_i,
    input  logic [BR_W-1:0]  br_type_i,
    input  logic [OFF_W-1:0] br_offset_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             running_o,
    output logic             ack_o,
    output logic             flag_z_o,
    output logic             flag_lt_o,
    output logic             taken_o
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, ack_q;
    logic            flag_we, flag_clr;
    logic [PC_W-1:0] off_ext;

    assign off_ext = PC_W'($signed(br_offset_i));

    // Next-state, PC update and flag-register controls; branches see the registered flags.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flag_we  = 1'b0;
        flag_clr = 1'b0;
        taken_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    pc_d     = start_addr_i;
                    flag_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    flag_we = flag_we_i;
                    taken_o = ((br_type_i == BR_BEQ) && flag_z_o)  ||
                              ((br_type_i == BR_BLT) && flag_lt_o) ||
                              (br_type_i == BR_JMP);
                    if (halt_i) begin
                        state_d = ST_DONE;
                    end else if (taken_o) begin
                        pc_d = pc_q + off_ext;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == ST_RUN);
            ack_q     <= (state_d == ST_DONE);
        end
    end

    branch_ctrl_flag_reg u_flag_reg (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (flag_clr),
        .we_i     (flag_we),
        .zero_i   (zero_i),
        .lt_i     (lt_i),
        .flag_z_o (flag_z_o),
        .flag_lt_o(flag_lt_o)
    );

    assign pc_o      = pc_q;
    assign running_o = running_q;
    assign ack_o     = ack_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Table-driven check of branch_ctrl with a scoreboard queue of post-edge expectations.
module tb_branch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, stall, halt, we, zin, ltin, taken;
    logic [9:0] addr, pc;
    logic [1:0] br;
    logic [7:0] off;
    logic       running, ack, fz, flt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.PC_W(10), .OFF_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .start_addr_i(addr),
        .stall_i     (stall),
        .halt_i      (halt),
        .flag_we_i   (we),
        .zero_i      (zin),
        .lt_i        (ltin),
        .br_type_i   (br),
        .br_offset_i (off),
        .pc_o        (pc),
        .running_o   (running),
        .ack_o       (ack),
        .flag_z_o    (fz),
        .flag_lt_o   (flt),
        .taken_o     (taken)
    );

    typedef struct {
        logic       rst_n, start;
        logic [9:0] addr;
        logic       stall, halt, we, z, lt;
        logic [1:0] br;
        logic [7:0] off;
        logic       e_tk;
        logic [9:0] e_pc;
        logic       e_run, e_ack, e_fz, e_flt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [9:0] pc;
        logic       run, ack, fz, flt;
    } exp_t;

    vec_t vecs[27];
    exp_t sbq[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [9:0] a,
                                input logic st, input logic h, input logic w,
                                input logic z, input logic l, input logic [1:0] b,
                                input logic [7:0] o, input logic tk, input logic [9:0] p,
                                input logic rn, input logic ak, input logic ez, input logic el);
        vec_t v;
        v.rst_n = r;  v.start = s; v.addr = a; v.stall = st; v.halt = h;
        v.we = w; v.z = z; v.lt = l; v.br = b; v.off = o;
        v.e_tk = tk; v.e_pc = p; v.e_run = rn; v.e_ack = ak; v.e_fz = ez; v.e_flt = el;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; start = v.start; addr = v.addr; stall = v.stall; halt = v.halt;
        we = v.we; zin = v.z; ltin = v.lt; br = v.br; off = v.off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vec_t idle_v;
        bit   got_ack;
        idle_v = mk(1,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h000,0,0,0,0);

        vecs[0]  = mk(0,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h000,0,0,0,0);
        vecs[1]  = mk(1,1,10'h010,0,0,0,0,0,2'd0,8'h00, 0,10'h010,1,0,0,0);
        vecs[2]  = mk(1,1,10'h200,0,0,0,0,0,2'd0,8'h00, 0,10'h011,1,0,0,0);
        vecs[3]  = mk(1,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h012,1,0,0,0);
        vecs[4]  = mk(1,0,10'h000,0,0,0,0,0,2'd3,8'd14, 1,10'h020,1,0,0,0);
        vecs[5]  = mk(1,0,10'h000,0,0,1,1,0,2'd0,8'h00, 0,10'h021,1,0,1,0);
        vecs[6]  = mk(1,0,10'h000,0,0,0,0,0,2'd1,8'hFC, 1,10'h01D,1,0,1,0);
        vecs[7]  = mk(1,0,10'h000,0,0,0,0,0,2'd3,8'd3,  1,10'h020,1,0,1,0);
        vecs[8]  = mk(1,0,10'h000,0,0,1,0,0,2'd0,8'h00, 0,10'h021,1,0,0,0);
        vecs[9]  = mk(1,0,10'h000,0,0,0,0,0,2'd1,8'hFC, 0,10'h022,1,0,0,0);
        vecs[10] = mk(1,0,10'h000,0,0,1,0,1,2'd2,8'd5,  0,10'h023,1,0,0,1);
        vecs[11] = mk(1,0,10'h000,0,0,0,0,0,2'd2,8'd5,  1,10'h028,1,0,0,1);
        vecs[12] = mk(1,0,10'h000,0,0,0,0,0,2'd3,8'd0,  1,10'h028,1,0,0,1);
        vecs[13] = mk(1,0,10'h000,1,1,1,1,0,2'd3,8'd5,  0,10'h028,1,0,0,1);
        vecs[14] = mk(1,0,10'h000,1,1,1,1,0,2'd3,8'd5,  0,10'h028,1,0,0,1);
        vecs[15] = mk(1,0,10'h000,1,1,1,1,0,2'd3,8'd5,  0,10'h028,1,0,0,1);
        vecs[16] = mk(1,0,10'h000,0,1,0,0,0,2'd0,8'd5,  0,10'h028,0,1,0,1);
        vecs[17] = mk(1,1,10'h3FE,0,0,0,0,0,2'd0,8'h00, 0,10'h028,0,1,0,1);
        vecs[18] = mk(1,0,10'h3FE,0,0,0,0,0,2'd0,8'h00, 0,10'h028,0,0,0,1);
        vecs[19] = mk(1,1,10'h3FE,0,0,0,0,0,2'd0,8'h00, 0,10'h3FE,1,0,0,0);
        vecs[20] = mk(1,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h3FF,1,0,0,0);
        vecs[21] = mk(1,0,10'h000,0,0,1,1,1,2'd0,8'h00, 0,10'h000,1,0,1,1);
        vecs[22] = mk(1,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h001,1,0,1,1);
        vecs[23] = mk(1,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h002,1,0,1,1);
        vecs[24] = mk(1,0,10'h000,0,0,0,0,0,2'd3,8'hFD, 1,10'h3FF,1,0,1,1);
        vecs[25] = mk(0,0,10'h000,1,0,0,0,0,2'd3,8'h00, 0,10'h000,0,0,0,0);
        vecs[26] = mk(1,0,10'h000,0,0,0,0,0,2'd0,8'h00, 0,10'h000,0,0,0,0);

        drive(idle_v);
        rst_n = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i]);
            #1;
            n_vec++;
            chk("taken", i, 32'(taken), 32'(vecs[i].e_tk));
            e.idx = i; e.pc = vecs[i].e_pc; e.run = vecs[i].e_run;
            e.ack = vecs[i].e_ack; e.fz = vecs[i].e_fz; e.flt = vecs[i].e_flt;
            sbq.push_back(e);
            tick();
            e = sbq.pop_front();
            chk("pc",      e.idx, 32'(pc),      32'(e.pc));
            chk("running", e.idx, 32'(running), 32'(e.run));
            chk("ack",     e.idx, 32'(ack),     32'(e.ack));
            chk("flag_z",  e.idx, 32'(fz),      32'(e.fz));
            chk("flag_lt", e.idx, 32'(flt),     32'(e.flt));
        end

        // Start, one sequential step, then halt: wait (bounded) for Ack with PC held.
        drive(idle_v);
        start = 1'b1;
        addr  = 10'h100;
        tick();
        start = 1'b0;
        tick();
        halt = 1'b1;
        got_ack = 1'b0;
        for (int c = 0; c < 8 && !got_ack; c++) begin
            tick();
            if (ack === 1'b1) got_ack = 1'b1;
        end
        n_vec++;
        chk("halt_ack_seen", 100, 32'(got_ack), 32'd1);
        chk("halt_pc_held",  100, 32'(pc),      32'h101);
        chk("halt_running",  100, 32'(running), 32'd0);
        halt = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter OFF_W, default 8, signed branch offset width in bits.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  reset, synchronous and active-low.
REQ-005 Start  input  1  request to begin execution; level, sampled in IDLE and DONE.
REQ-006 StartAddr  input  PC_W  PC loaded on accepted Start.
REQ-007 Stall  input  1  hold PC and state for this cycle.
REQ-008 Halt  input  1  current instruction is halt.
REQ-009 FlagWe  input  1  latch ZeroIn/LTIn this cycle (compare/arith instruction).
REQ-010 ZeroIn  input  1  ALU Zero result.
REQ-011 LTIn  input  1  ALU less-than result (unsigned A<B).
REQ-012 BrType  input  2  00 none, 01 BEQ (on FlagZ), 10 BLT (on FlagLT), 11 JMP (unconditional).
REQ-013 BrOffset  input  OFF_W  signed two's-complement PC-relative offset.
REQ-014 PC  output  PC_W  current instruction address, registered.
REQ-015 Running  output  1  high in RUN.
REQ-016 Ack  output  1  high in DONE.
REQ-017 FlagZ  output  1  latched Zero flag, registered.
REQ-018 FlagLT  output  1  latched LT flag, registered.
REQ-019 Taken  output  1  combinational: branch condition true in RUN with Stall low.

Function
REQ-020 FSM states IDLE, RUN, DONE; encoding 2 bits.
REQ-021 IDLE: Start=1 -> RUN next cycle, PC<=StartAddr, flags<=0; else hold.
REQ-022 RUN, Stall=1: PC, state, flags all hold; Halt, FlagWe, BrType ignored; Taken=0.
REQ-023 RUN, Stall=0, Halt=1: -> DONE, PC holds; Halt overrides BrType; FlagWe still honored.
REQ-024 RUN, Stall=0, Halt=0, Taken=1: PC<=PC+sign_extend(BrOffset), mod 2^PC_W.
REQ-025 RUN, Stall=0, Halt=0, Taken=0: PC<=PC+1, mod 2^PC_W (wrap max->0).
REQ-026 Taken = (BrType==01 & FlagZ) | (BrType==10 & FlagLT) | (BrType==11), gated per REQ-019.
REQ-027 Branch evaluates registered flags; FlagWe and branch in same cycle -> branch uses old flags, new flags visible next cycle.
REQ-028 FlagWe=1 in RUN, Stall=0: FlagZ<=ZeroIn, FlagLT<=LTIn; otherwise flags hold.
REQ-029 Offset 0 with Taken=1 -> PC unchanged (self-loop), legal.
REQ-030 DONE: Ack=1; Start=0 -> IDLE; Start=1 -> stay DONE (no re-launch until Start drops).
REQ-031 Start while RUN ignored.
REQ-032 Latency: PC change visible one cycle after decision edge; no bubbles inserted.

Reset
REQ-033 Reset_n=0 at a rising edge -> state IDLE, PC=0, FlagZ=0, FlagLT=0, regardless of state or Stall.
REQ-034 Outputs after reset: Running=0, Ack=0, Taken=0.
REQ-035 Reset mid-RUN abandons execution; no Ack generated.

Structure
REQ-036 Shared package holds FSM state typedef, BrType encoding constants, default PC_W/OFF_W.
REQ-037 One sub-module natural: flag_reg (FlagWe-gated 2-bit register with hold).
REQ-038 Offset sign-extension and PC adder in top level; no other sub-modules.

Verification
REQ-039 Reset, Start=1 StartAddr=0x010 -> Running=1, PC=0x010, then 0x011, 0x012 each cycle.
REQ-040 FlagWe ZeroIn=1 at PC=0x020, next cycle BEQ offset -4 -> PC=0x01D; same with ZeroIn=0 -> PC=0x022.
REQ-041 FlagWe LTIn=1 together with BLT offset +5, prior FlagLT=0 -> not taken (PC+1); BLT next cycle -> taken.
REQ-042 PC=0x3FF, no branch -> PC=0x000; PC=0x002, JMP offset -3 -> PC=0x3FF.
REQ-043 Stall=1 for 3 cycles with JMP and Halt asserted -> PC, flags, state unchanged, Taken=0.
REQ-044 Halt -> Ack=1, PC held; Start held high -> stays DONE; Start=0 -> IDLE; Reset_n=0 mid-RUN -> IDLE, PC=0, no Ack.
